// File: rtl/xtl_timebase_pkg.sv
// Shared constants and width helper for the crystal-clock timebase.
package xtl_timebase_pkg;

    localparam int unsigned DIV_US_DEF    = 16;
    localparam int unsigned US_PER_MS_DEF = 1000;
    localparam int unsigned MS_PER_S_DEF  = 1000;
    localparam int unsigned SEC_W_DEF     = 32;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 2) begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/xtl_mod_cnt.sv
// Modulo-N counter with clear, hold and increment; registered wrap strobe plus
// a same-cycle wrap condition for cascading into the next stage.
module xtl_mod_cnt
    import xtl_timebase_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                hold_i,
    input  logic                inc_i,
    output logic [cnt_w(N)-1:0] cnt_o,
    output logic                wrap_o,
    output logic                wrap_c
);

    localparam int unsigned  W   = cnt_w(N);
    localparam logic [W-1:0] MAX = W'(N - 1);

    logic [W-1:0] cnt_d, cnt_q;
    logic         wrap_d, wrap_q;
    logic         step_c;

    assign step_c = inc_i & ~hold_i & ~clr_i;
    assign wrap_c = step_c & (cnt_q == MAX);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = wrap_c;
        if (clr_i) begin
            cnt_d = '0;
        end else if (step_c) begin
            cnt_d = wrap_c ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/xtl_timebase.sv
// Free-running us/ms/s strobe generator with a CPU-loadable seconds counter.
module xtl_timebase
    import xtl_timebase_pkg::*;
#(
    parameter int unsigned DIV_US    = DIV_US_DEF,
    parameter int unsigned US_PER_MS = US_PER_MS_DEF,
    parameter int unsigned MS_PER_S  = MS_PER_S_DEF,
    parameter int unsigned SEC_W     = SEC_W_DEF
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    input  logic                       EN,
    input  logic                       SEC_LOAD,
    input  logic [SEC_W-1:0]           SEC_LOAD_VAL,
    output logic                       TICK_US,
    output logic                       TICK_MS,
    output logic                       TICK_S,
    output logic [cnt_w(MS_PER_S)-1:0] MS_CNT,
    output logic [SEC_W-1:0]           SEC_CNT,
    output logic                       LOAD_ACK
);

    logic [cnt_w(DIV_US)-1:0]    pre_cnt_unused;
    logic [cnt_w(US_PER_MS)-1:0] us_cnt_unused;
    logic                        pre_wrap_c, us_wrap_c, ms_wrap_c;
    logic [SEC_W-1:0]            sec_d, sec_q;
    logic                        ack_d, ack_q;

    xtl_mod_cnt #(.N(DIV_US)) u_pre (
        .clk_i  (CLK),
        .rst_ni (RESETN),
        .clr_i  (SEC_LOAD),
        .hold_i (~EN),
        .inc_i  (EN),
        .cnt_o  (pre_cnt_unused),
        .wrap_o (TICK_US),
        .wrap_c (pre_wrap_c)
    );

    xtl_mod_cnt #(.N(US_PER_MS)) u_us (
        .clk_i  (CLK),
        .rst_ni (RESETN),
        .clr_i  (SEC_LOAD),
        .hold_i (~EN),
        .inc_i  (pre_wrap_c),
        .cnt_o  (us_cnt_unused),
        .wrap_o (TICK_MS),
        .wrap_c (us_wrap_c)
    );

    xtl_mod_cnt #(.N(MS_PER_S)) u_ms (
        .clk_i  (CLK),
        .rst_ni (RESETN),
        .clr_i  (SEC_LOAD),
        .hold_i (~EN),
        .inc_i  (us_wrap_c),
        .cnt_o  (MS_CNT),
        .wrap_o (TICK_S),
        .wrap_c (ms_wrap_c)
    );

    // A load discards a coincident second increment.
    always_comb begin
        sec_d = sec_q;
        ack_d = 1'b0;
        if (SEC_LOAD) begin
            sec_d = SEC_LOAD_VAL;
            ack_d = 1'b1;
        end else if (ms_wrap_c) begin
            sec_d = sec_q + SEC_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            sec_q <= '0;
            ack_q <= 1'b0;
        end else begin
            sec_q <= sec_d;
            ack_q <= ack_d;
        end
    end

    assign SEC_CNT  = sec_q;
    assign LOAD_ACK = ack_q;

endmodule
